// File: rtl/decoder_pkg.sv
// Shared types and helpers for the one-hot decoder family.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest select any decoder in this family supports; callers slice the result.
  localparam int MAX_SEL_W = 8;

  function automatic logic [2**MAX_SEL_W-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
    logic [2**MAX_SEL_W-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational select -> one-hot decode; en=0 drives every line low.
module onehot_dec #(
  parameter int SEL_W = 3
) (
  input  logic                en,
  input  logic [SEL_W-1:0]    sel,
  output logic [2**SEL_W-1:0] dec
);

  for (genvar i = 0; i < 2**SEL_W; i++) begin : g_line
    assign dec[i] = en & (sel == SEL_W'(i));
  end

endmodule

// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with a handshaked DIRECT mode and an
// auto-advancing SCAN mode with programmable per-line dwell.
module scan_decoder
  import decoder_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int DWELL_W    = 8,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mode,
  input  logic                addr_valid,
  input  logic [SEL_W-1:0]    addr,
  output logic                addr_ready,
  input  logic [DWELL_W-1:0]  dwell,
  output logic [2**SEL_W-1:0] dec_out,
  output logic [SEL_W-1:0]    cur_sel,
  output logic                line_act,
  output logic                wrap
);

  localparam int               LINES    = 2**SEL_W;
  localparam logic [LINES-1:0] IDLE_LVL = {LINES{ACTIVE_LOW}};
  localparam logic [LINES-1:0] LINE0    = LINES'(1);

  state_t                      state;
  logic [SEL_W-1:0]            sel_q;
  logic [DWELL_W-1:0]          cnt_q;
  logic                        act_q;
  logic                        wrap_q;
  logic [LINES-1:0]            dec_q;

  // Decoder 0 serves DIRECT accepts, decoder 1 pre-decodes the next scan line,
  // so the output flop loads a ready-made one-hot word in either mode.
  logic [1:0][SEL_W-1:0]       dec_sel;
  logic [1:0][LINES-1:0]       dec_vec;

  assign dec_sel[0] = addr;
  assign dec_sel[1] = sel_q + 1'b1;

  for (genvar g = 0; g < 2; g++) begin : g_dec
    onehot_dec #(.SEL_W(SEL_W)) u_dec (
      .en  (1'b1),
      .sel (dec_sel[g]),
      .dec (dec_vec[g])
    );
  end

  function automatic logic [LINES-1:0] pol(input logic [LINES-1:0] v);
    return ACTIVE_LOW ? ~v : v;
  endfunction

  assign addr_ready = en & (mode == MODE_DIRECT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sel_q  <= '0;
      cnt_q  <= '0;
      act_q  <= 1'b0;
      wrap_q <= 1'b0;
      dec_q  <= IDLE_LVL;
    end else begin
      wrap_q <= 1'b0;
      if (!en) begin
        state <= IDLE;
        sel_q <= '0;
        cnt_q <= '0;
        act_q <= 1'b0;
        dec_q <= IDLE_LVL;
      end else if (mode == MODE_SCAN) begin
        act_q <= 1'b1;
        if (state != SCAN) begin
          state <= SCAN;
          sel_q <= '0;
          cnt_q <= dwell;
          dec_q <= pol(LINE0);
        end else if (cnt_q == '0) begin
          // dwell is sampled only here, so mid-line changes wait for the next line
          sel_q  <= sel_q + 1'b1;
          cnt_q  <= dwell;
          dec_q  <= pol(dec_vec[1]);
          wrap_q <= (sel_q == '1);
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end else begin
        state <= DIRECT;
        cnt_q <= '0;
        if (addr_valid) begin
          sel_q <= addr;
          act_q <= 1'b1;
          dec_q <= pol(dec_vec[0]);
        end else if (state != DIRECT) begin
          // entering DIRECT without an accept: dark until the first address
          sel_q <= '0;
          act_q <= 1'b0;
          dec_q <= IDLE_LVL;
        end
      end
    end
  end

  assign dec_out  = dec_q;
  assign cur_sel  = sel_q;
  assign line_act = act_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed + randomized checks of scan_decoder (default, active-low and 4-bit builds)
// against a line/hold-time reference model.
module tb_scan_decoder;

  int total = 0;
  int bad   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, mode, av;
  logic [2:0] addr;
  logic [7:0] dwell;
  logic [7:0] dec, dec_lo;
  logic [2:0] sel, sel_lo;
  logic       act, act_lo, wrap, wrap_lo, rdy, rdy_lo;

  logic        en4, mode4, av4;
  logic [3:0]  addr4, dwell4, sel4;
  logic [15:0] dec4;
  logic        act4, wrap4, rdy4;

  scan_decoder u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .addr_valid(av), .addr(addr),
    .addr_ready(rdy), .dwell(dwell), .dec_out(dec), .cur_sel(sel), .line_act(act), .wrap(wrap)
  );

  scan_decoder #(.ACTIVE_LOW(1'b1)) u_lo (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .addr_valid(av), .addr(addr),
    .addr_ready(rdy_lo), .dwell(dwell), .dec_out(dec_lo), .cur_sel(sel_lo), .line_act(act_lo),
    .wrap(wrap_lo)
  );

  scan_decoder #(.SEL_W(4), .DWELL_W(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .mode(mode4), .addr_valid(av4), .addr(addr4),
    .addr_ready(rdy4), .dwell(dwell4), .dec_out(dec4), .cur_sel(sel4), .line_act(act4), .wrap(wrap4)
  );

  // Reference model: which line is lit (-1 = none) and how many cycles it has left.
  localparam int PH_OFF = 0, PH_DIR = 1, PH_SCAN = 2;
  int m_ph[2];
  int m_line[2];
  int m_left[2];
  bit m_wrap[2];

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = PH_OFF; m_line[k] = -1; m_left[k] = 0; m_wrap[k] = 1'b0;
    end
  endtask

  task automatic model(input int k, input logic e, input logic m, input logic v,
                       input int a, input int d, input int n);
    m_wrap[k] = 1'b0;
    if (!e) begin
      m_ph[k] = PH_OFF; m_line[k] = -1;
    end else if (m) begin
      if (m_ph[k] != PH_SCAN) begin
        m_ph[k] = PH_SCAN; m_line[k] = 0; m_left[k] = d + 1;
      end else begin
        m_left[k]--;
        if (m_left[k] == 0) begin
          m_line[k] = (m_line[k] + 1) % n;
          m_wrap[k] = (m_line[k] == 0);
          m_left[k] = d + 1;
        end
      end
    end else begin
      if (m_ph[k] != PH_DIR) begin
        m_ph[k] = PH_DIR; m_line[k] = -1;
      end
      if (v) m_line[k] = a;
    end
  endtask

  function automatic logic [31:0] exp_dec(input int k);
    return (m_line[k] < 0) ? 32'd0 : (32'd1 << m_line[k]);
  endfunction

  function automatic logic [31:0] exp_sel(input int k);
    return (m_line[k] < 0) ? 32'd0 : 32'(m_line[k]);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s differs: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare();
    check("dec",     32'(dec),     exp_dec(0));
    check("dec_lo",  32'(dec_lo),  ~exp_dec(0) & 32'hFF);
    check("sel",     32'(sel),     exp_sel(0));
    check("sel_lo",  32'(sel_lo),  exp_sel(0));
    check("act",     32'(act),     32'(m_line[0] >= 0));
    check("act_lo",  32'(act_lo),  32'(m_line[0] >= 0));
    check("wrap",    32'(wrap),    32'(m_wrap[0]));
    check("wrap_lo", 32'(wrap_lo), 32'(m_wrap[0]));
    check("rdy",     32'(rdy),     32'(en & ~mode));
    check("rdy_lo",  32'(rdy_lo),  32'(en & ~mode));
    check("dec4",    32'(dec4),    exp_dec(1));
    check("sel4",    32'(sel4),    exp_sel(1));
    check("act4",    32'(act4),    32'(m_line[1] >= 0));
    check("wrap4",   32'(wrap4),   32'(m_wrap[1]));
    check("rdy4",    32'(rdy4),    32'(en4 & ~mode4));
  endtask

  task automatic step();
    @(posedge clk);
    model(0, en, mode, av, int'(addr), int'(dwell), 8);
    model(1, en4, mode4, av4, int'(addr4), int'(dwell4), 16);
    #1;
    compare();
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; mode = 1'b0; av = 1'b0; addr = '0; dwell = '0;
    en4 = 1'b0; mode4 = 1'b0; av4 = 1'b0; addr4 = '0; dwell4 = '0;
    mreset();

    // T1: reset values
    #1 rst_n = 1'b0;
    #2;
    compare();
    check("rst_dec_lo", 32'(dec_lo), 32'hFF);
    #9 rst_n = 1'b1;

    // T2: DIRECT accept, hold, re-accept
    en = 1'b1; mode = 1'b0; av = 1'b1; addr = 3'd5;
    step(); check("t2_a5", 32'(dec), 32'h20);
    av = 1'b0;
    repeat (10) begin step(); check("t2_hold", 32'(dec), 32'h20); end
    av = 1'b1; addr = 3'd0;
    step(); check("t2_a0", 32'(dec), 32'h01);
    step(); check("t2_reacc", 32'(dec), 32'h01);
    repeat (30) begin
      av = 1'($urandom_range(0, 1)); addr = 3'($urandom_range(0, 7));
      step();
    end

    // T3: SCAN dwell=0, wrap on the second line 0 (addr_valid ignored)
    mode = 1'b1; dwell = 8'd0; av = 1'b1;
    for (int t = 0; t < 9; t++) begin
      step();
      check("t3_dec", 32'(dec), 32'd1 << (t % 8));
      check("t3_wrap", 32'(wrap), 32'(t == 8));
    end

    // T4: dwell=2, dropped to 0 in the middle of line 3
    en = 1'b0; av = 1'b0; step();
    en = 1'b1; mode = 1'b1; dwell = 8'd2;
    for (int t = 0; t < 16; t++) begin
      step();
      check("t4_dec", 32'(dec), 32'd1 << ((t < 12) ? (t / 3) : (4 + t - 12)));
      if (t == 10) dwell = 8'd0;
    end

    // Async reset mid-scan
    #2 rst_n = 1'b0;
    #1;
    check("ar_dec", 32'(dec), 32'h00);
    check("ar_sel", 32'(sel), 32'd0);
    check("ar_wrap", 32'(wrap), 32'd0);
    check("ar_act", 32'(act), 32'd0);
    check("ar_dec_lo", 32'(dec_lo), 32'hFF);
    mreset();
    @(negedge clk) rst_n = 1'b1;
    step(); check("ar_restart", 32'(dec), 32'h01);
    repeat (8) step();

    // T5: mode/enable races
    mode = 1'b0; av = 1'b1; addr = 3'd3;
    step(); check("t5_sw_acc3", 32'(dec), 32'h08);
    en = 1'b0; addr = 3'd6;
    step(); check("t5_endrop", 32'(dec), 32'h00); check("t5_endrop_act", 32'(act), 32'd0);
    en = 1'b1; mode = 1'b1; dwell = 8'd1; av = 1'b0;
    repeat (4) step();
    mode = 1'b0; av = 1'b1; addr = 3'd6;
    step(); check("t5_sw_acc6", 32'(dec), 32'h40);
    mode = 1'b1; av = 1'b0; step();
    mode = 1'b0; step(); check("t5_sw_dark", 32'(dec), 32'h00);

    // Randomized mix on the 3-bit builds
    repeat (300) begin
      en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      dwell = 8'($urandom_range(0, 3));
      av = 1'($urandom_range(0, 1)); addr = 3'($urandom_range(0, 7));
      step();
    end

    // T6: 4-bit build, full 16-line scan then random DIRECT
    en = 1'b0; step();
    en4 = 1'b1; mode4 = 1'b1; dwell4 = 4'd0;
    for (int t = 0; t < 17; t++) begin
      step();
      check("t6_sel", 32'(sel4), 32'(t % 16));
      check("t6_wrap", 32'(wrap4), 32'(t == 16));
    end
    dwell4 = 4'd15;
    repeat (40) step();
    mode4 = 1'b0;
    repeat (100) begin
      av4 = 1'($urandom_range(0, 1)); addr4 = 4'($urandom_range(0, 15));
      step();
      check("t6_onehot", 32'($countones(dec4) <= 1), 32'd1);
      check("t6_or", 32'(act4), 32'(|dec4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
